// File: rtl/wide_fifo_if.sv
// wide_fifo_if: write/read/status bundle between a client and wide_fifo.
// The client side uses the master modport, the FIFO uses the slave modport.
interface wide_fifo_if #(
  parameter int DATA_W = 285,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] Data;
  logic              WrEn;
  logic              RdEn;
  logic              ClrErr;
  logic [DATA_W-1:0] Q;
  logic              Empty;
  logic              Full;
  logic              AlmostEmpty;
  logic              AlmostFull;
  logic [ADDR_W:0]   Count;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output Data, WrEn, RdEn, ClrErr,
    input  Q, Empty, Full, AlmostEmpty, AlmostFull,
    input  Count, Overflow, Underflow
  );

  modport slave (
    input  Data, WrEn, RdEn, ClrErr,
    output Q, Empty, Full, AlmostEmpty, AlmostFull,
    output Count, Overflow, Underflow
  );
endinterface

// File: rtl/wide_fifo.sv
// wide_fifo: single-clock block-RAM FIFO with level flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output with prefetch.
module wide_fifo #(
  parameter int DATA_W   = 285,
  parameter int ADDR_W   = 9,
  parameter int AE_LEVEL = 4,
  parameter int AF_LEVEL = 508
) (
  input  logic       Clock,
  input  logic       Reset,
  wide_fifo_if.slave f
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [ADDR_W-1:0] P1  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] q_q;

  logic wr_acc;
  logic rd_acc;
  logic ram_rd;

  assign wr_acc = f.WrEn && !full_q;
  assign rd_acc = f.RdEn && !empty_q;

  always_ff @(posedge Clock) begin
    if (wr_acc && !Reset) begin
      mem[wr_ptr_q] <= f.Data;
    end
  end

`ifdef FIFO_FWFT_EN
  // s1 is the RAM read register, q_q the prefetch output register
  logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
  logic              s1_v_q, s1_v_d;
  logic              s2_v_q, s2_v_d;
  logic [DATA_W-1:0] s1_q;
  logic              s1_mv;

  assign s1_mv  = s1_v_q && (!s2_v_q || rd_acc);
  assign ram_rd = (ram_cnt_q != '0) && (!s1_v_q || s1_mv);

  always_comb begin
    ram_cnt_d = ram_cnt_q;
    case ({wr_acc, ram_rd})
      2'b10:   ram_cnt_d = ram_cnt_q + ONE_C;
      2'b01:   ram_cnt_d = ram_cnt_q - ONE_C;
      default: ram_cnt_d = ram_cnt_q;
    endcase
    s1_v_d = ram_rd || (s1_v_q && !s1_mv);
    s2_v_d = s1_mv || (s2_v_q && !rd_acc);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ram_cnt_q <= '0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_q      <= '0;
      q_q       <= '0;
    end else begin
      ram_cnt_q <= ram_cnt_d;
      s1_v_q    <= s1_v_d;
      s2_v_q    <= s2_v_d;
      if (ram_rd) s1_q <= mem[rd_ptr_q];
      if (s1_mv)  q_q  <= s1_q;
    end
  end
`else
  assign ram_rd = rd_acc;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q <= '0;
    end else if (ram_rd) begin
      q_q <= mem[rd_ptr_q];
    end
  end
`endif

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + P1 : wr_ptr_q;
    rd_ptr_d = ram_rd ? rd_ptr_q + P1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + ONE_C;
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase
`ifdef FIFO_FWFT_EN
    empty_d = !s2_v_d;
`else
    empty_d = (cnt_d == '0);
`endif
    full_d = (cnt_d == DEPTH_C);
    ae_d   = (cnt_d <= AE_C);
    af_d   = (cnt_d >= AF_C);
    // a new error event in the same cycle as ClrErr keeps the flag set
    ovf_d  = (ovf_q && !f.ClrErr) || (f.WrEn && full_q);
    unf_d  = (unf_q && !f.ClrErr) || (f.RdEn && empty_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign f.Q           = q_q;
  assign f.Count       = cnt_q;
  assign f.Empty       = empty_q;
  assign f.Full        = full_q;
  assign f.AlmostEmpty = ae_q;
  assign f.AlmostFull  = af_q;
  assign f.Overflow    = ovf_q;
  assign f.Underflow   = unf_q;
endmodule
